// File: rtl/sw_debounce_hex_if.sv
// Switch-conditioning bus between the raw DE10-Lite switches and the HEX0 display stage.
// Carries the raw switches in and the debounced levels, change strobe and segment drive out.
interface sw_debounce_hex_if #(
  parameter int unsigned N_SW = 10
);
  logic [N_SW-1:0] SW;
  logic [N_SW-1:0] SW_DB;
  logic            CHG;
  logic [7:0]      HEX0;

  modport master (
    output SW,
    input  SW_DB,
    input  CHG,
    input  HEX0
  );

  modport slave (
    input  SW,
    output SW_DB,
    output CHG,
    output HEX0
  );
endinterface

// File: rtl/sw_debounce_hex.sv
// Per-bit two-flop synchroniser and debouncer for the slide switches, with a change strobe
// and HEX0 drive. Define SW_DEBOUNCE_HEX_DECODE_EN to show SW_DB[3:0] as an active-low hex glyph.
module sw_debounce_hex #(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  sw_debounce_hex_if.slave  io
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      RawW    = (N_SW < 8) ? N_SW : 8;
  localparam int unsigned      NibW    = (N_SW < 4) ? N_SW : 4;

  logic [N_SW-1:0]  sync1_q, sync1_d;
  logic [N_SW-1:0]  sync2_q, sync2_d;
  logic [N_SW-1:0]  db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];
  logic             chg_q, chg_d;
  logic [7:0]       hex;

  // Counter only runs while the synchronised level disagrees with the accepted one, so any
  // return to the old level (bounce) zeroes it and timing restarts from the last transition.
  always_comb begin
    sync1_d = io.SW;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    chg_d = |(db_d ^ db_q);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      chg_q   <= chg_d;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef SW_DEBOUNCE_HEX_DECODE_EN
  logic [3:0] nib;

  // Active-low segments, bit0=a .. bit6=g; bit7 (DP) held off.
  always_comb begin
    nib = 4'(db_q[NibW-1:0]);
    hex = 8'hFF;
    unique case (nib)
      4'h0: hex = 8'hC0;
      4'h1: hex = 8'hF9;
      4'h2: hex = 8'hA4;
      4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h92;
      4'h6: hex = 8'h82;
      4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;
      4'h9: hex = 8'h90;
      4'hA: hex = 8'h88;
      4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;
      4'hD: hex = 8'hA1;
      4'hE: hex = 8'h86;
      4'hF: hex = 8'h8E;
    endcase
  end
`else
  always_comb begin
    hex = 8'(db_q[RawW-1:0]);
  end
`endif

  assign io.SW_DB = db_q;
  assign io.CHG   = chg_q;
  assign io.HEX0  = hex;

endmodule
